// File: rtl/insn_sequencer.sv
// Instruction sequencer: layer constants, 2-D addressed buffer bursts and CONVOLVE window timing.
// Optional stall counter built only when SEQ_PERF_CNT_EN is defined.
module insn_sequencer #(
    parameter int W     = 16,
    parameter int AB    = 11,
    parameter int AL    = 7,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8,
    parameter int INS_W = 4 + 2 + CNT_W + W
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             ins_valid,
    output logic             ins_ready,
    input  logic [INS_W-1:0] ins,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic [W-1:0]     din,
    output logic             buf_we,
    output logic             buf_sel,
    output logic [DEPTH-1:0] buf_bank,
    output logic [AB-1:0]    buf_addr,
    output logic [W-1:0]     buf_wdata,
    output logic             conv_en,
    output logic [1:0]       conv_mode,
    output logic             busy,
    output logic             err,
    output logic [31:0]      perf_stall_cnt
);

    typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, CONV = 2'd2} state_t;

    localparam logic [3:0] OP_LOAD_N = 4'b0000;
    localparam logic [3:0] OP_LOAD_K = 4'b0001;
    localparam logic [3:0] OP_SET_C  = 4'b0010;
    localparam logic [3:0] OP_CONV   = 4'b1010;
    localparam logic [AL-1:0]    AL_ONE    = {{(AL-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DEPTH-1:0] DEPTH_ONE = {{(DEPTH-1){1'b0}}, 1'b1};

    // Opcodes that are accepted as no-operations; everything else undecoded is illegal.
    function automatic logic is_illegal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b1010,
            4'b1000, 4'b1001, 4'b1011, 4'b1100, 4'b1110, 4'b1111: is_illegal = 1'b0;
            default: is_illegal = 1'b1;
        endcase
    endfunction

    state_t state_r, state_next_s;

    logic [3:0]       opcode_s;
    logic [1:0]       mode_s;
    logic [CNT_W-1:0] cnt_s;
    logic [W-1:0]     imm_s;
    logic             accept_s;
    logic             beat_s;
    logic             unused_s;

    logic             ins_ready_r, din_ready_r, busy_r, err_r;
    logic [AL-1:0]    row_len_r, n_stride_r, k_stride_r;
    logic [AB-1:0]    base_r, row_off_r;
    logic [AL-1:0]    stride_r, col_r, len_m1_s;
    logic [DEPTH-1:0] bank_r;
    logic [CNT_W-1:0] beats_left_r, conv_left_r;
    logic             sel_r, bank_inc_r;
    logic             buf_we_r, buf_sel_r, conv_en_r;
    logic [DEPTH-1:0] buf_bank_r;
    logic [AB-1:0]    buf_addr_r;
    logic [W-1:0]     buf_wdata_r;
    logic [1:0]       conv_mode_r;

    assign opcode_s = ins[INS_W-1 -: 4];
    assign mode_s   = ins[INS_W-5 -: 2];
    assign cnt_s    = ins[W+CNT_W-1:W];
    assign imm_s    = ins[W-1:0];
    assign unused_s = ^{imm_s, cnt_s};
    assign accept_s = ins_valid && ins_ready_r;
    assign beat_s   = (state_r == BURST) && din_valid;
    // A row length of zero behaves like a row length of one.
    assign len_m1_s = (row_len_r == {AL{1'b0}}) ? {AL{1'b0}} : (row_len_r - AL_ONE);

    // State register.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) state_r <= IDLE;
        else       state_r <= state_next_s;
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    case (opcode_s)
                        OP_LOAD_N, OP_LOAD_K: state_next_s = BURST;
                        OP_CONV:              state_next_s = CONV;
                        default:              state_next_s = IDLE;
                    endcase
                end else begin
                    state_next_s = IDLE;
                end
            end
            BURST: begin
                if (din_valid && (beats_left_r == {CNT_W{1'b0}})) state_next_s = IDLE;
                else                                               state_next_s = BURST;
            end
            CONV: begin
                if (conv_left_r == {CNT_W{1'b0}}) state_next_s = IDLE;
                else                              state_next_s = CONV;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Handshake and status flags, registered from the next state so they track state_r.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ins_ready_r <= 1'b0;
            din_ready_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            ins_ready_r <= (state_next_s == IDLE);
            din_ready_r <= (state_next_s == BURST);
            busy_r      <= (state_next_s != IDLE);
        end
    end

    // Layer constants and sticky error flag.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            row_len_r  <= {AL{1'b0}};
            n_stride_r <= {AL{1'b0}};
            k_stride_r <= {AL{1'b0}};
            err_r      <= 1'b0;
        end else if (accept_s) begin
            if (opcode_s == OP_SET_C) begin
                case (cnt_s[1:0])
                    2'd0:    row_len_r  <= imm_s[AL-1:0];
                    2'd1:    n_stride_r <= imm_s[AL-1:0];
                    2'd2:    k_stride_r <= imm_s[AL-1:0];
                    default: row_len_r  <= row_len_r;
                endcase
            end
            if (is_illegal(opcode_s)) err_r <= 1'b1;
        end
    end

    // Burst context: captured on LOAD acceptance, advanced on every accepted beat.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            base_r       <= {AB{1'b0}};
            row_off_r    <= {AB{1'b0}};
            stride_r     <= {AL{1'b0}};
            col_r        <= {AL{1'b0}};
            bank_r       <= {DEPTH{1'b0}};
            beats_left_r <= {CNT_W{1'b0}};
            sel_r        <= 1'b0;
            bank_inc_r   <= 1'b0;
        end else if (accept_s && ((opcode_s == OP_LOAD_N) || (opcode_s == OP_LOAD_K))) begin
            base_r       <= imm_s[AB-1:0];
            bank_r       <= imm_s[AB+DEPTH-1:AB];
            stride_r     <= opcode_s[0] ? k_stride_r : n_stride_r;
            row_off_r    <= {AB{1'b0}};
            col_r        <= {AL{1'b0}};
            beats_left_r <= cnt_s;
            sel_r        <= opcode_s[0];
            bank_inc_r   <= (mode_s == 2'b10);
        end else if (beat_s) begin
            if (col_r == len_m1_s) begin
                col_r     <= {AL{1'b0}};
                row_off_r <= row_off_r + {{(AB-AL){1'b0}}, stride_r};
                if (bank_inc_r) bank_r <= bank_r + DEPTH_ONE;
            end else begin
                col_r <= col_r + AL_ONE;
            end
            if (beats_left_r != {CNT_W{1'b0}}) beats_left_r <= beats_left_r - CNT_ONE;
        end
    end

    // Buffer write port, one cycle behind the accepted beat; address held between beats.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            buf_we_r    <= 1'b0;
            buf_sel_r   <= 1'b0;
            buf_bank_r  <= {DEPTH{1'b0}};
            buf_addr_r  <= {AB{1'b0}};
            buf_wdata_r <= {W{1'b0}};
        end else begin
            buf_we_r <= beat_s;
            if (beat_s) begin
                buf_sel_r   <= sel_r;
                buf_bank_r  <= bank_r;
                buf_addr_r  <= base_r + row_off_r + {{(AB-AL){1'b0}}, col_r};
                buf_wdata_r <= din;
            end
        end
    end

    // CONVOLVE window timer.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            conv_en_r   <= 1'b0;
            conv_mode_r <= 2'b00;
            conv_left_r <= {CNT_W{1'b0}};
        end else if (accept_s && (opcode_s == OP_CONV)) begin
            conv_en_r   <= 1'b1;
            conv_mode_r <= mode_s;
            conv_left_r <= cnt_s;
        end else if (state_r == CONV) begin
            if (conv_left_r == {CNT_W{1'b0}}) begin
                conv_en_r   <= 1'b0;
                conv_mode_r <= 2'b00;
            end else begin
                conv_left_r <= conv_left_r - CNT_ONE;
            end
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_r;
    // Saturating count of BURST cycles with no data offered.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN)                                                      perf_r <= 32'd0;
        else if ((state_r == BURST) && !din_valid && (perf_r != 32'hFFFF_FFFF)) perf_r <= perf_r + 32'd1;
    end
    assign perf_stall_cnt = perf_r;
`else
    assign perf_stall_cnt = 32'd0;
`endif

    assign ins_ready = ins_ready_r;
    assign din_ready = din_ready_r;
    assign busy      = busy_r;
    assign err       = err_r;
    assign buf_we    = buf_we_r;
    assign buf_sel   = buf_sel_r;
    assign buf_bank  = buf_bank_r;
    assign buf_addr  = buf_addr_r;
    assign buf_wdata = buf_wdata_r;
    assign conv_en   = conv_en_r;
    assign conv_mode = conv_mode_r;

endmodule

// File: doc/insn_sequencer.md
Name: insn_sequencer

Overview:
Parametrised successor to the fixed-width master controller. It accepts instruction words over a valid/ready handshake and holds the layer constants. It runs multi-beat neuron and kernel buffer loads with 2-D address generation, and times CONVOLVE windows of programmable length. It sits between the host instruction stream and the buffer, conv-unit and pool-unit control inputs, and stalls the stream while a multi-cycle operation is in progress.

Parameters:
W, 16, data/immediate width (must be >= AB+DEPTH)
AB, 11, buffer address width
AL, 7, constant (stride/row length) width
DEPTH, 2, log2 of banks/PE rows; D = 1<<DEPTH
CNT_W, 8, repeat-count field width
INS_W, 4+2+CNT_W+W, instruction width, derived

Ports:
CLK  in  1  clock, rising edge
RSTN  in  1  async active-low reset
ins_valid  in  1  instruction offered
ins_ready  out  1  sequencer accepts instruction
ins  in  INS_W  {opcode[3:0], mode[1:0], cnt[CNT_W-1:0], imm[W-1:0]}
din_valid  in  1  burst data beat offered
din_ready  out  1  burst data beat accepted
din  in  W  burst data
buf_we  out  1  buffer write strobe (registered)
buf_sel  out  1  0 = neuron buffer, 1 = kernel buffer
buf_bank  out  DEPTH  target bank
buf_addr  out  AB  write address
buf_wdata  out  W  write data
conv_en  out  1  convolve window active
conv_mode  out  2  mode field of the active CONVOLVE
busy  out  1  state != IDLE
err  out  1  sticky illegal-opcode flag
perf_stall_cnt  out  32  stall counter (see Optional Feature)

Behaviour:
- Reset (RSTN=0, async): state=IDLE; all outputs 0 except ins_ready=1 once RSTN=1; constants ROW_LEN, N_STRIDE, K_STRIDE all 0; err=0.
- States: IDLE, BURST, CONV.
- ins_ready=1 only in IDLE. An instruction is accepted on ins_valid&&ins_ready.
- Opcode 0010 SET_CONST, stays in IDLE, writes imm[AL-1:0] to the constant selected by cnt[1:0]:
  - 0 = ROW_LEN, 1 = N_STRIDE, 2 = K_STRIDE, 3 = no-op.
  - The new value is visible to an instruction accepted the next cycle.
- Opcodes 0000 LOAD_N and 0001 LOAD_K go to BURST:
  - beats = cnt+1; base = imm[AB-1:0]; bank = imm[AB+DEPTH-1:AB].
  - stride = N_STRIDE for LOAD_N, K_STRIDE for LOAD_K.
  - col and row both start at 0.
- In BURST:
  - din_ready=1.
  - Each accepted beat: the next cycle drives buf_we=1, buf_addr=(base+row*stride+col) mod 2^AB, buf_wdata=din, buf_sel, buf_bank. Latency 1.
  - After the beat, col increments. When col==ROW_LEN-1, col wraps to 0 and row increments. ROW_LEN=0 is treated as 1.
  - din_valid low: no strobe; the address is held.
  - Last beat accepted: state goes to IDLE that cycle; ins_ready=1 in the following cycle.
- mode on LOAD_*: 10 post-increments the bank (modulo D) on every row wrap; any other value keeps the bank fixed.
- Opcode 1010 CONVOLVE goes to CONV:
  - conv_en=1 and conv_mode=mode for exactly cnt+1 cycles, starting the cycle after acceptance.
  - Then returns to IDLE; conv_mode returns to 0.
- Opcodes 1000, 1001, 1011, 1100, 1110, 1111 are accepted as 1-cycle NOPs in IDLE.
- Any other opcode: accepted, err set sticky until reset, no other effect.
- buf_we is never asserted outside a BURST beat. Only one operation is active at a time.
- Reset mid-BURST or mid-CONV aborts immediately; buf_we and conv_en drop asynchronously.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- When defined: perf_stall_cnt counts cycles with state==BURST and din_valid==0. It saturates at 2^32-1 and is cleared by reset.
- When undefined: perf_stall_cnt is tied to 0 and no counter logic is built.

Test Plan:
- SET_CONST ROW_LEN=3, N_STRIDE=8; LOAD_N cnt=5 base=0x10 bank=1, din_valid held high -> six strobes at addr 0x10,0x11,0x12,0x18,0x19,0x1A, bank 1, data matching din, ins_ready low for 6 cycles.
- LOAD_K mode=10, ROW_LEN=2, K_STRIDE=4, cnt=5, bank=3 -> addr 0,1,4,5,8,9 with bank 3,3,0,0,1,1.
- CONVOLVE cnt=3 mode=01 -> conv_en high for exactly 4 cycles starting 1 cycle after acceptance, conv_mode=01; busy low the cycle after conv_en falls.
- LOAD_N cnt=2 with din_valid toggled 1,0,0,1,1 -> exactly 3 strobes at consecutive addresses; perf_stall_cnt=2 with SEQ_PERF_CNT_EN defined, 0 without.
- Base 0x7FE, ROW_LEN=0, N_STRIDE=1, cnt=3 -> addr 0x7FE,0x7FF,0x000,0x001 (wrap mod 2^11).
- Opcode 0101 -> err=1 and stays 1. RSTN pulsed low mid-BURST -> buf_we=0 immediately, err=0, state IDLE, ins_ready=1 after release.
